// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the instruction fetch stage
package fetch_pkg;

    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_INCR         = 32'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// rtl/instr_fetch_stage_if.sv - combinational instruction ROM read bus
interface instr_fetch_stage_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - next-PC select (hold / +4 / redirect) and PC register
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    logic [31:0] pc_next;

    // Load beats hold so a redirect always wins over a stall.
    always_comb begin
        pc_next = pc + PC_INCR;
        if (load) begin
            pc_next = target & ~32'h3;
        end else if (hold) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - IF stage: PC, ROM fetch, IF/ID register, halt FSM; FETCH_STATS_EN adds counters
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INSTR  = FETCH_NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_target,
    input  logic                   halt_req,
    instr_fetch_stage_if.master    rom,
    output logic [31:0]            pc,
    output logic [31:0]            ifid_pc,
    output logic [DATA_WIDTH-1:0]  ifid_instr,
    output logic                   ifid_valid,
    output logic                   halted,
    output logic                   addr_err,
    output logic [31:0]            fetch_cnt,
    output logic [31:0]            bubble_cnt
);

    fetch_state_t state;

    logic running;
    logic pc_load;
    logic pc_hold;
    logic normal_fetch;
    logic bubble_evt;
    logic pc_bad;

    assign running      = (state == ST_RUN);
    assign pc_load      = running & ~halt_req & redirect;
    assign pc_hold      = ~running | halt_req | stall;
    assign normal_fetch = running & ~halt_req & ~redirect & ~stall;
    assign bubble_evt   = running & (halt_req | redirect);

    // Upper PC bits are dropped from the ROM index, so out-of-range PCs wrap.
    assign rom.rom_addr = pc[ADDR_WIDTH+1:2];
    assign pc_bad       = (pc[1:0] != 2'b00) || ((pc >> (ADDR_WIDTH + 2)) != 32'd0);
    assign halted       = (state == ST_HALTED);

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk    (clk),
        .rst    (rst),
        .hold   (pc_hold),
        .load   (pc_load),
        .target (redirect_target),
        .pc     (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            ifid_pc    <= 32'd0;
            ifid_instr <= NOP_INSTR[DATA_WIDTH-1:0];
            ifid_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state      <= ST_HALTED;
                        ifid_instr <= NOP_INSTR[DATA_WIDTH-1:0];
                        ifid_valid <= 1'b0;
                    end else if (redirect) begin
                        ifid_instr <= NOP_INSTR[DATA_WIDTH-1:0];
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr <= rom.rom_data;
                        ifid_pc    <= pc;
                        ifid_valid <= 1'b1;
                        if (pc_bad) begin
                            addr_err <= 1'b1;
                        end
                    end
                end
                // The bubble loaded on entry stays put until reset.
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (normal_fetch) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (bubble_evt) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = normal_fetch ^ bubble_evt;
    assign fetch_cnt    = 32'd0;
    assign bubble_cnt   = 32'd0;
`endif

endmodule
